// File: rtl/vector_scatter_pkg.sv
// Shared vector datapath parameters and scatter engine types.
// Imported by the scatter interface, lane picker and top.
package vector_scatter_pkg;

    localparam int VECTOR_REG_DEPTH = 8;
    localparam int VECTOR_REG_WIDTH = 32;
    localparam int ADDR_W = (VECTOR_REG_DEPTH > 1) ? $clog2(VECTOR_REG_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCATTER = 2'd1,
        S_DONE    = 2'd2
    } vector_scatter_state_t;

    // Out-of-range entries only exist for non-power-of-two depths.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (VECTOR_REG_DEPTH == (1 << ADDR_W)) ||
               (int'(32'(a)) < VECTOR_REG_DEPTH);
    endfunction

endpackage

// File: rtl/vector_scatter_if.sv
// Request bus of the scatter engine: one MAP_PORT-lane write request
// with a valid/ready handshake.
interface vector_scatter_if
    import vector_scatter_pkg::*;
#(
    parameter int MAP_PORT = 8
);
    logic                                       req_valid;
    logic                                       req_ready;
    logic [MAP_PORT-1:0]                        req_vld;
    logic [MAP_PORT-1:0][ADDR_W-1:0]            req_addr;
    logic [MAP_PORT-1:0][VECTOR_REG_WIDTH-1:0]  req_data;

    modport master (
        output req_valid, req_vld, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_vld, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/vector_lane_picker.sv
// Selects the lowest WR_PORTS set bits of the pending mask, one lane
// per slot in ascending order, and returns the mask left over.
module vector_lane_picker #(
    parameter int MAP_PORT = 8,
    parameter int WR_PORTS = 4
) (
    input  logic [MAP_PORT-1:0]               pend_i,
    output logic [WR_PORTS-1:0][MAP_PORT-1:0] sel_o,
    output logic [MAP_PORT-1:0]               rest_o
);
    logic [MAP_PORT-1:0] m;
    logic [MAP_PORT-1:0] low;

    always_comb begin
        sel_o = '0;
        m     = pend_i;
        low   = '0;
        for (int s = 0; s < WR_PORTS; s++) begin
            // Isolate the lowest set bit; zero when the mask is exhausted.
            low      = m & (-m);
            sel_o[s] = low;
            m        = m & ~low;
        end
        rest_o = m;
    end

endmodule

// File: rtl/vector_scatter.sv
// Multi-cycle scatter engine: latches one request, then commits up to
// WR_PORTS lane writes per cycle into the vector register array.
module vector_scatter
    import vector_scatter_pkg::*;
#(
    parameter int MAP_PORT = 8,
    parameter int WR_PORTS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    vector_scatter_if.slave         req,
    input  logic                    clr,
    output logic                    busy,
    output logic                    done,
    output logic                    conflict,
    output logic [VECTOR_REG_DEPTH-1:0][VECTOR_REG_WIDTH-1:0] reg_out
);
    typedef logic [MAP_PORT-1:0]                        mask_t;
    typedef logic [MAP_PORT-1:0][ADDR_W-1:0]            lane_addr_t;
    typedef logic [MAP_PORT-1:0][VECTOR_REG_WIDTH-1:0]  lane_data_t;
    typedef logic [VECTOR_REG_DEPTH-1:0][VECTOR_REG_WIDTH-1:0] arr_t;

    vector_scatter_state_t state_q, state_d;
    mask_t      pend_q, pend_d, pend_rest;
    lane_addr_t addr_q, addr_d;
    lane_data_t data_q, data_d;
    logic       conf_q, conf_d;
    arr_t       arr_q, arr_d;
    logic       same_addr;

    logic [WR_PORTS-1:0][MAP_PORT-1:0] sel;

    vector_lane_picker #(
        .MAP_PORT (MAP_PORT),
        .WR_PORTS (WR_PORTS)
    ) u_pick (
        .pend_i (pend_q),
        .sel_o  (sel),
        .rest_o (pend_rest)
    );

    always_comb begin
        same_addr = 1'b0;
        for (int i = 0; i < MAP_PORT; i++) begin
            for (int j = i + 1; j < MAP_PORT; j++) begin
                if (req.req_vld[i] && req.req_vld[j] &&
                    req.req_addr[i] == req.req_addr[j]) begin
                    same_addr = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        addr_d        = addr_q;
        data_d        = data_q;
        conf_d        = conf_q;
        arr_d         = arr_q;
        req.req_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req.req_ready = !clr;
                if (clr) begin
                    arr_d = '0;
                end else if (req.req_valid) begin
                    pend_d  = req.req_vld;
                    addr_d  = req.req_addr;
                    data_d  = req.req_data;
                    conf_d  = same_addr;
                    state_d = (req.req_vld != '0) ? S_SCATTER : S_DONE;
                end
            end
            S_SCATTER: begin
                // Slots are in ascending lane order, so later slots win.
                for (int s = 0; s < WR_PORTS; s++) begin
                    logic [ADDR_W-1:0]           wa;
                    logic [VECTOR_REG_WIDTH-1:0] wd;
                    wa = '0;
                    wd = '0;
                    for (int i = 0; i < MAP_PORT; i++) begin
                        if (sel[s][i]) begin
                            wa = wa | addr_q[i];
                            wd = wd | data_q[i];
                        end
                    end
                    if ((sel[s] != '0) && addr_ok(wa)) begin
                        arr_d[wa] = wd;
                    end
                end
                pend_d = pend_rest;
                if (pend_rest == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            conf_q  <= 1'b0;
            arr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            conf_q  <= conf_d;
            arr_q   <= arr_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign conflict = conf_q;
    assign reg_out  = arr_q;

endmodule

// File: tb/tb_vector_scatter.sv
// Self-checking bench for vector_scatter: directed table, corner
// sequences and random requests against a lane-ordered array model.
module tb_vector_scatter;
    import vector_scatter_pkg::*;

    localparam int NL = 8;

    typedef logic [NL-1:0]                        vld_t;
    typedef logic [NL-1:0][ADDR_W-1:0]            addr_t;
    typedef logic [NL-1:0][VECTOR_REG_WIDTH-1:0]  data_t;
    typedef logic [VECTOR_REG_DEPTH-1:0][VECTOR_REG_WIDTH-1:0] arr_t;

    typedef struct {
        vld_t  vld;
        addr_t addr;
        data_t data;
        logic  conf;
        int    lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr = 1'b0;
    logic busy, done, conflict;
    arr_t rout;

    int checks = 0;
    int errors = 0;
    arr_t mem = '0;

    vector_scatter_if #(.MAP_PORT(NL)) bus ();

    vector_scatter #(.MAP_PORT(NL), .WR_PORTS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus),
        .clr      (clr),
        .busy     (busy),
        .done     (done),
        .conflict (conflict),
        .reg_out  (rout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Final array: each active lane writes in lane order, last one wins.
    task automatic model_apply(input vld_t v, input addr_t a, input data_t d);
        for (int i = 0; i < NL; i++)
            if (v[i]) mem[a[i]] = d[i];
    endtask

    function automatic logic model_conf(input vld_t v, input addr_t a);
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NL; j++)
                if (i != j && v[i] && v[j] && a[i] == a[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_lat(input vld_t v);
        return ($countones(v) + 3) / 4 + 1;
    endfunction

    // Drive one request, hold a garbage request during busy, and
    // report accept-to-done latency.
    task automatic run_req(input vld_t v, input addr_t a, input data_t d,
                           output int lat);
        int t;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            step();
            t++;
        end
        chk("ready_wait", {255'd0, bus.req_ready}, 256'd1);
        bus.req_valid = 1'b1;
        bus.req_vld   = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        step();
        bus.req_vld  = ~v;
        bus.req_addr = ~a;
        bus.req_data = ~d;
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        bus.req_valid = 1'b0;
        chk("ready_in_done", {255'd0, bus.req_ready}, 256'd0);
    endtask

    vec_t tbl[4];
    int   lat;
    int   seen_done;
    vld_t  rv;
    addr_t ra;
    data_t rd;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_vld   = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        for (int i = 0; i < NL; i++) begin
            tbl[0].addr[i] = ADDR_W'(7 - i);
            tbl[0].data[i] = 32'h100 + 32'(i);
        end
        tbl[0].vld  = 8'hFF;
        tbl[0].conf = 1'b0;
        tbl[0].lat  = 3;

        tbl[1].vld     = 8'b0100_0010;
        tbl[1].addr    = '0;
        tbl[1].data    = '0;
        tbl[1].addr[1] = 3'd2;
        tbl[1].addr[6] = 3'd2;
        tbl[1].data[1] = 32'hA;
        tbl[1].data[6] = 32'hB;
        tbl[1].conf    = 1'b1;
        tbl[1].lat     = 2;

        tbl[2].vld  = 8'h00;
        tbl[2].addr = '0;
        tbl[2].data = {NL{32'hDEAD_BEEF}};
        tbl[2].conf = 1'b0;
        tbl[2].lat  = 1;

        tbl[3].vld  = 8'b0001_0101;
        tbl[3].addr = {3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd4, 3'd0, 3'd1};
        tbl[3].data = '0;
        tbl[3].data[0] = 32'h11;
        tbl[3].data[2] = 32'h22;
        tbl[3].data[4] = 32'h33;
        tbl[3].conf = 1'b0;
        tbl[3].lat  = 2;

        // Reset held while idle
        step();
        step();
        chk("rst_reg_out", rout, 256'd0);
        chk("rst_ready", {255'd0, bus.req_ready}, 256'd1);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_conflict", {255'd0, conflict}, 256'd0);
        reset = 1'b0;
        step();

        foreach (tbl[k]) begin
            run_req(tbl[k].vld, tbl[k].addr, tbl[k].data, lat);
            model_apply(tbl[k].vld, tbl[k].addr, tbl[k].data);
            chk($sformatf("tbl%0d_latency", k), 256'(lat), 256'(tbl[k].lat));
            chk($sformatf("tbl%0d_conflict", k), {255'd0, conflict},
                {255'd0, tbl[k].conf});
            chk($sformatf("tbl%0d_reg_out", k), rout, mem);
            if (k == 0) chk("tbl0_entry0", 256'(rout[0]), 256'h107);
            if (k == 1) chk("tbl1_entry2", 256'(rout[2]), 256'hB);
            step();
            chk($sformatf("tbl%0d_idle", k), {255'd0, busy}, 256'd0);
        end

        // All lanes to entry 5: intermediate and final winners
        for (int i = 0; i < NL; i++) begin
            ra[i] = 3'd5;
            rd[i] = 32'(i);
        end
        bus.req_valid = 1'b1;
        bus.req_vld   = 8'hFF;
        bus.req_addr  = ra;
        bus.req_data  = rd;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("same5_first", 256'(rout[5]), 256'd3);
        chk("same5_first_done", {255'd0, done}, 256'd0);
        step();
        chk("same5_second", 256'(rout[5]), 256'd7);
        chk("same5_done", {255'd0, done}, 256'd1);
        chk("same5_conflict", {255'd0, conflict}, 256'd1);
        model_apply(8'hFF, ra, rd);
        step();

        // Clear in idle
        clr = 1'b1;
        #1;
        chk("clr_ready", {255'd0, bus.req_ready}, 256'd0);
        step();
        clr = 1'b0;
        mem = '0;
        chk("clr_reg_out", rout, 256'd0);

        // Random requests
        for (int r = 0; r < 40; r++) begin
            rv = vld_t'($urandom);
            if (r % 8 == 0) rv = '0;
            for (int i = 0; i < NL; i++) begin
                ra[i] = ADDR_W'($urandom_range(VECTOR_REG_DEPTH - 1, 0));
                rd[i] = $urandom;
            end
            run_req(rv, ra, rd, lat);
            model_apply(rv, ra, rd);
            chk($sformatf("rnd%0d_latency", r), 256'(lat), 256'(model_lat(rv)));
            chk($sformatf("rnd%0d_conflict", r), {255'd0, conflict},
                {255'd0, model_conf(rv, ra)});
            chk($sformatf("rnd%0d_reg_out", r), rout, mem);
            step();
        end

        // Reset between the two write cycles
        for (int i = 0; i < NL; i++) begin
            ra[i] = ADDR_W'(7 - i);
            rd[i] = 32'h200 + 32'(i);
        end
        bus.req_valid = 1'b1;
        bus.req_vld   = 8'hFF;
        bus.req_addr  = ra;
        bus.req_data  = rd;
        step();
        bus.req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("midrst_reg_out", rout, 256'd0);
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        chk("midrst_ready", {255'd0, bus.req_ready}, 256'd1);
        chk("midrst_done", {255'd0, done}, 256'd0);
        step();
        reset = 1'b0;
        mem = '0;
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done) seen_done++;
        end
        chk("midrst_no_done", 256'(seen_done), 256'd0);
        chk("midrst_array", rout, mem);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_scatter.md
# vector_scatter

Multi-cycle scatter engine: accepts one MAP_PORT-lane request (per-lane valid, destination address, data) and writes each active lane's data into an internal VECTOR_REG_DEPTH-entry vector register at its address. Writes are throttled to WR_PORTS lanes per cycle. Same-address conflicts resolve deterministically to the highest lane. It is the write-side counterpart of the gather/mapping path in the vector datapath: the mapper reads by address, this block writes by address.

## Interface
- MAP_PORT, 8, number of request lanes
- WR_PORTS, 4, lane writes committed per cycle (1..MAP_PORT)
- clk  in  1  clock; one clock domain, all logic rising-edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- req_vld  in  1 x [MAP_PORT]  per-lane active flag
- req_addr  in  $clog2(VECTOR_REG_DEPTH) x [MAP_PORT]  per-lane destination entry
- req_data  in  VECTOR_REG_WIDTH x [MAP_PORT]  per-lane write data
- clr  in  1  synchronous clear of the register array, honoured only in IDLE
- busy  out  1  high in SCATTER and DONE
- done  out  1  one-cycle pulse, request fully written
- conflict  out  1  two or more active lanes of the last accepted request share an address
- reg_out  out  VECTOR_REG_WIDTH x [VECTOR_REG_DEPTH]  current array contents, registered

## Operation
- States: IDLE, SCATTER, DONE.
- IDLE: req_ready = !clr. With clr=1: array zeroed at next edge, no request accepted. With req_valid && req_ready: latch req_vld into pending mask, latch addr and data, compute conflict. Next state is SCATTER if mask != 0, else DONE.
- SCATTER: each cycle select the lowest-numbered set bits of pending, up to WR_PORTS of them. Write them to the array in ascending lane order, so the higher lane wins on a same-address collision within a cycle. Clear the selected bits. Later cycles carry higher lanes, so across the whole request the highest active lane wins. When pending becomes 0 at this edge, next state is DONE.
- DONE: done=1, req_ready=0, next state IDLE.
- req_valid while not ready: ignored, no latch. The requester holds the request.
- clr outside IDLE: ignored.
- conflict: updated only on accept. It holds until the next accept.
- Reset: state IDLE, pending 0, array all zero, done 0, conflict 0, busy 0, req_ready 1. Reset mid-SCATTER aborts the request. Reset clears the array, so no partial result survives.

## Timing
- Accept at edge E0. Let N = ceil(popcount(req_vld)/WR_PORTS).
- Writes commit at edges E1..EN. reg_out shows each write in the cycle after its edge.
- done is high in the cycle after EN (for an empty mask, the cycle after E0).
- The next accept is possible at edge EN+2.
- Throughput: one request per N+2 cycles (2 cycles for an empty mask).
- Addresses are unsigned and must be < VECTOR_REG_DEPTH. For non-power-of-two depth, an out-of-range address drops that lane's write silently.

## Structure
- VECTOR_REG_DEPTH and VECTOR_REG_WIDTH come from the shared vector package.
- The state enum (vector_scatter_state_t) goes in the same package.
- One sub-module: vector_lane_picker. It is combinational: input pending mask, output a one-hot-per-slot select of the lowest WR_PORTS set bits plus the remaining mask.
- The FSM, latches and array stay in vector_scatter.

## Test plan
Bench values: VECTOR_REG_DEPTH=8, VECTOR_REG_WIDTH=32, defaults.
- Reset asserted mid-idle -> reg_out all 0, req_ready=1, busy=0, done=0, conflict=0.
- All 8 lanes valid, addr[i]=7-i, data[i]=0x100+i -> 2 write cycles. done in the 3rd cycle after accept. reg_out[7-i]=0x100+i. conflict=0. req_valid held during busy is not accepted.
- Lanes 1 and 6 valid, both addr 2, data 0xA and 0xB -> 1 write cycle, reg_out[2]=0xB, conflict=1.
- All 8 lanes valid, all addr 5, data[i]=i -> after lanes 0-3 commit, reg_out[5]=3. After the second write cycle, reg_out[5]=7. conflict=1.
- req_vld=0 accepted -> done pulse the cycle after accept, array unchanged. Then clr=1 in IDLE -> req_ready=0 that cycle and array all 0 next cycle.
- Reset asserted between the two write cycles of the 8-lane request -> immediately IDLE, array all 0, done never pulses.
